ripple_carry_adder: RTL and testbench

//   Parameterised N-bit ripple-carry adder/subtractor with ALU status flags (zero,

---
 rtl/alu_pkg.sv | 14 +
 rtl/full_adder.sv | 23 ++
 rtl/ripple_carry_adder.sv | 100 ++++++++++
 tb/tb_ripple_carry_adder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings for the operation select and operand interpretation mode.
// Latency: none (constants only).
// Backpressure: not applicable.
package alu_pkg;

    // add_sub_b encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // sign encodings
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple-carry chain.
// Latency: combinational.
// Backpressure: none; always accepts inputs.
//
// Ports:
//   a, b  operand bits
//   cin   carry in from the next-lower stage
//   s     sum bit
//   cout  carry out to the next-higher stage
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder/subtractor with zero/negative/carry/overflow flags.
// Latency: 0 cycles when REGISTER_OUTPUT=0, 1 cycle when REGISTER_OUTPUT=1.
// Backpressure: none; a new result is produced for every input set.
//
// Ports:
//   clk        clock, used only by the optional output register
//   rst        synchronous active-high reset of the output register
//   add_sub_b  0 = in1+in2, 1 = in1-in2
//   sign       0 = unsigned, 1 = two's-complement (gates n and v)
//   in1, in2   operands
//   out        result modulo 2^BUS_WIDTH
//   z, n, c, v zero, negative, carry (no-borrow on subtract), signed overflow
module ripple_carry_adder
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH       = 8,
    parameter bit REGISTER_OUTPUT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 add_sub_b,
    input  logic                 sign,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    output logic [BUS_WIDTH-1:0] out,
    output logic                 z,
    output logic                 n,
    output logic                 c,
    output logic                 v
);

    typedef struct packed {
        logic [BUS_WIDTH-1:0] sum;
        logic                 z;
        logic                 n;
        logic                 c;
        logic                 v;
    } res_t;

    // Value the register holds after reset: zero result, so z is set.
    localparam res_t RES_RESET = '{sum: '0, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};

    logic [BUS_WIDTH-1:0] b_eff;
    logic [BUS_WIDTH-1:0] sum;
    logic [BUS_WIDTH:0]   carry;

    // Subtract is in1 + ~in2 + 1: invert B and inject the +1 as carry-in.
    always_comb begin
        b_eff    = in2 ^ {BUS_WIDTH{add_sub_b == OP_SUB}};
        carry[0] = (add_sub_b == OP_SUB);
    end

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (in1[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    res_t res_comb;
    res_t res_d;
    res_t res_q;

    always_comb begin
        res_comb.sum = sum;
        res_comb.z   = (sum == '0);
        res_comb.n   = (sign == MODE_SIGNED) & sum[BUS_WIDTH-1];
        res_comb.c   = carry[BUS_WIDTH];
        // Signed overflow: carry into the MSB disagrees with carry out of it.
        res_comb.v   = (sign == MODE_SIGNED) & (carry[BUS_WIDTH-1] ^ carry[BUS_WIDTH]);
    end

    // Reset wins over capture, so an in-flight result is simply discarded.
    always_comb begin
        res_d = res_comb;
        if (rst) begin
            res_d = RES_RESET;
        end
    end

    // The register is always described; in combinational mode nothing reads it.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    res_t res_out;

    always_comb begin
        res_out = REGISTER_OUTPUT ? res_q : res_comb;
        out     = res_out.sum;
        z       = res_out.z;
        n       = res_out.n;
        c       = res_out.c;
        v       = res_out.v;
    end

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Directed checks of the adder in combinational and registered configurations.
// Latency: checks combinational results #1 after drive, registered results #1 after the edge.
// Backpressure: not applicable.
module tb_ripple_carry_adder;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         add_sub_b;
    logic         sign;
    logic [W-1:0] in1;
    logic [W-1:0] in2;

    logic [W-1:0] out_c, out_r;
    logic         z_c, n_c, c_c, v_c;
    logic         z_r, n_r, c_r, v_r;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.BUS_WIDTH(W), .REGISTER_OUTPUT(1'b0)) u_dut_comb (
        .clk(clk), .rst(rst), .add_sub_b(add_sub_b), .sign(sign),
        .in1(in1), .in2(in2),
        .out(out_c), .z(z_c), .n(n_c), .c(c_c), .v(v_c)
    );

    ripple_carry_adder #(.BUS_WIDTH(W), .REGISTER_OUTPUT(1'b1)) u_dut_reg (
        .clk(clk), .rst(rst), .add_sub_b(add_sub_b), .sign(sign),
        .in1(in1), .in2(in2),
        .out(out_r), .z(z_r), .n(n_r), .c(c_r), .v(v_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic op, input logic md, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        add_sub_b = op;
        sign      = md;
        in1       = a;
        in2       = b;
    endtask

    // Combinational vector: drive, settle, compare all five outputs.
    task automatic vec_comb(input string tag, input logic op, input logic md,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] e_out, input logic e_z, input logic e_n,
                            input logic e_c, input logic e_v);
        drive(op, md, a, b);
        #1;
        chk({tag, ".out"}, 32'(out_c), 32'(e_out));
        chk({tag, ".z"},   32'(z_c),   32'(e_z));
        chk({tag, ".n"},   32'(n_c),   32'(e_n));
        chk({tag, ".c"},   32'(c_c),   32'(e_c));
        chk({tag, ".v"},   32'(v_c),   32'(e_v));
    endtask

    task automatic chk_reg(input string tag, input logic [W-1:0] e_out, input logic e_z,
                           input logic e_n, input logic e_c, input logic e_v);
        chk({tag, ".out"}, 32'(out_r), 32'(e_out));
        chk({tag, ".z"},   32'(z_r),   32'(e_z));
        chk({tag, ".n"},   32'(n_r),   32'(e_n));
        chk({tag, ".c"},   32'(c_r),   32'(e_c));
        chk({tag, ".v"},   32'(v_r),   32'(e_v));
    endtask

    initial begin
        rst = 1'b0;
        drive(OP_ADD, MODE_UNSIGNED, 8'd0, 8'd0);

        // ---------------- combinational instance ----------------
        //        tag          op      mode           a       b       out     z     n     c     v
        vec_comb("add12_24",   OP_ADD, MODE_UNSIGNED, 8'd12,  8'd24,  8'd36,  1'b0, 1'b0, 1'b0, 1'b0);
        vec_comb("sub110_24",  OP_SUB, MODE_UNSIGNED, 8'd110, 8'd24,  8'd86,  1'b0, 1'b0, 1'b1, 1'b0);
        vec_comb("add110_220", OP_ADD, MODE_UNSIGNED, 8'd110, 8'd220, 8'd74,  1'b0, 1'b0, 1'b1, 1'b0);
        // Unsigned mode masks n and v even though the MSB is set.
        vec_comb("sub110_220u",OP_SUB, MODE_UNSIGNED, 8'd110, 8'd220, 8'd146, 1'b0, 1'b0, 1'b0, 1'b0);
        // Signed: 110 - (-36) = 146 does not fit, carry into MSB 1, out of MSB 0.
        vec_comb("sub110_220s",OP_SUB, MODE_SIGNED,   8'd110, 8'd220, 8'd146, 1'b0, 1'b1, 1'b0, 1'b1);
        vec_comb("s127p1",     OP_ADD, MODE_SIGNED,   8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
        vec_comb("s100m100",   OP_SUB, MODE_SIGNED,   8'd100, 8'd100, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0);
        vec_comb("zero_add",   OP_ADD, MODE_UNSIGNED, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 1'b0);
        vec_comb("xmx",        OP_SUB, MODE_UNSIGNED, 8'd55,  8'd55,  8'd0,   1'b1, 1'b0, 1'b1, 1'b0);
        vec_comb("zm1u",       OP_SUB, MODE_UNSIGNED, 8'd0,   8'd1,   8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
        vec_comb("zm1s",       OP_SUB, MODE_SIGNED,   8'd0,   8'd1,   8'd255, 1'b0, 1'b1, 1'b0, 1'b0);
        vec_comb("smin_m1",    OP_SUB, MODE_SIGNED,   8'd128, 8'd1,   8'd127, 1'b0, 1'b0, 1'b1, 1'b1);
        vec_comb("all1_p1",    OP_ADD, MODE_UNSIGNED, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b1, 1'b0);
        vec_comb("a5_p5a",     OP_ADD, MODE_SIGNED,   8'hA5,  8'h5A,  8'hFF,  1'b0, 1'b1, 1'b0, 1'b0);

        // rst has no effect on the combinational instance.
        rst = 1'b1;
        vec_comb("comb_rst",   OP_ADD, MODE_UNSIGNED, 8'd12,  8'd24,  8'd36,  1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- registered instance ----------------
        @(negedge clk);
        rst = 1'b1;
        drive(OP_ADD, MODE_SIGNED, 8'd127, 8'd1);
        @(posedge clk); #1;
        chk_reg("reg_rst", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        drive(OP_ADD, MODE_UNSIGNED, 8'd12, 8'd24);
        #1;
        // Not yet captured: still holding the reset value.
        chk_reg("reg_pre", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_reg("reg_add", 8'd36, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        drive(OP_ADD, MODE_SIGNED, 8'd127, 8'd1);
        #1;
        chk_reg("reg_hold", 8'd36, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_reg("reg_ovf", 8'd128, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset coinciding with new inputs drops them.
        @(negedge clk);
        rst = 1'b1;
        drive(OP_SUB, MODE_UNSIGNED, 8'd110, 8'd24);
        @(posedge clk); #1;
        chk_reg("reg_midrst", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reg("reg_resume", 8'd86, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_ripple_carry_adder
